iguana_gpio_debounce: RTL

//  Per-pin GPIO input conditioner between the GPIO input pads and the SoC gpio_i port.

---
 rtl/iguana_pkg.sv | 13 +
 rtl/iguana_gpio_db_chan.sv | 125 ++++++++++++
 rtl/iguana_gpio_debounce.sv | 40 ++++
 3 files changed

// File: rtl/iguana_pkg.sv
// Shared constants and types for the iguana SoC GPIO input path.
package iguana_pkg;

    localparam int unsigned IguanaGpioNum        = 12;
    localparam int unsigned IguanaGpioDbCntWidth = 16;
    localparam int unsigned IguanaGpioGlitchW    = 8;

    typedef enum logic {
        GpioDbStable,
        GpioDbCheck
    } gpio_db_state_e;

endpackage

// File: rtl/iguana_gpio_db_chan.sv
// One GPIO pin: synchronizer, debounce FSM, edge pulses, optional glitch count.
// Glitch counter is built only when IGUANA_GPIO_GLITCH_CNT_EN is defined.
module iguana_gpio_db_chan
    import iguana_pkg::*;
#(
    parameter int unsigned CntWidth   = IguanaGpioDbCntWidth,
    parameter int unsigned SyncStages = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic [CntWidth-1:0]          cycles_i,
    input  logic                         pad_i,
    input  logic                         clr_i,
    output logic                         gpio_o,
    output logic                         rise_o,
    output logic                         fall_o,
    output logic [IguanaGpioGlitchW-1:0] glitch_cnt_o
);

    logic [SyncStages-1:0] sync_q, sync_d;
    gpio_db_state_e        state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  s_q, s_d;
    logic                  rise_q, rise_d;
    logic                  fall_q, fall_d;
    logic                  sync;
    logic                  glitch;

    assign sync   = sync_q[SyncStages-1];
    assign sync_d = {sync_q[SyncStages-2:0], pad_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            state_q <= GpioDbStable;
            cnt_q   <= '0;
            s_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Accept at cnt==D, so the counter never needs to wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        glitch  = 1'b0;
        if (!en_i) begin
            state_d = GpioDbStable;
            cnt_d   = '0;
            s_d     = sync;
        end else begin
            unique case (state_q)
                GpioDbStable: begin
                    if (sync != s_q) begin
                        state_d = GpioDbCheck;
                        cnt_d   = '0;
                    end
                end
                GpioDbCheck: begin
                    if (sync == s_q) begin
                        state_d = GpioDbStable;
                        cnt_d   = '0;
                        glitch  = 1'b1;
                    end else if (cnt_q >= cycles_i) begin
                        state_d = GpioDbStable;
                        cnt_d   = '0;
                        s_d     = ~s_q;
                    end else begin
                        cnt_d = cnt_q + CntWidth'(1);
                    end
                end
                default: begin
                    state_d = GpioDbStable;
                    cnt_d   = '0;
                end
            endcase
        end
        rise_d = s_d & ~s_q;
        fall_d = ~s_d & s_q;
    end

    always_comb begin
        gpio_o = s_q;
        rise_o = rise_q;
        fall_o = fall_q;
    end

`ifdef IGUANA_GPIO_GLITCH_CNT_EN
    logic [IguanaGpioGlitchW-1:0] gcnt_q, gcnt_d;

    always_comb begin
        gcnt_d = gcnt_q;
        if (clr_i) begin
            gcnt_d = '0;
        end else if (glitch && (gcnt_q != '1)) begin
            gcnt_d = gcnt_q + IguanaGpioGlitchW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gcnt_q <= '0;
        end else begin
            gcnt_q <= gcnt_d;
        end
    end

    assign glitch_cnt_o = gcnt_q;
`else
    logic unused_glitch;
    assign unused_glitch = glitch ^ clr_i;
    assign glitch_cnt_o  = '0;
`endif

endmodule

// File: rtl/iguana_gpio_debounce.sv
// GPIO pad input conditioner: per-pin sync + debounce with shared window.
// Optional per-pin glitch counters via IGUANA_GPIO_GLITCH_CNT_EN.
module iguana_gpio_debounce
    import iguana_pkg::*;
#(
    parameter int unsigned NumGpio    = IguanaGpioNum,
    parameter int unsigned CntWidth   = IguanaGpioDbCntWidth,
    parameter int unsigned SyncStages = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           debounce_en_i,
    input  logic [CntWidth-1:0]            debounce_cycles_i,
    input  logic [NumGpio-1:0]             gpio_pad_i,
    output logic [NumGpio-1:0]             gpio_o,
    output logic [NumGpio-1:0]             rise_o,
    output logic [NumGpio-1:0]             fall_o,
    input  logic [NumGpio-1:0]             glitch_clr_i,
    output logic [NumGpio*IguanaGpioGlitchW-1:0] glitch_cnt_o
);

    for (genvar i = 0; i < NumGpio; i++) begin : g_chan
        iguana_gpio_db_chan #(
            .CntWidth   (CntWidth),
            .SyncStages (SyncStages)
        ) u_chan (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .en_i         (debounce_en_i),
            .cycles_i     (debounce_cycles_i),
            .pad_i        (gpio_pad_i[i]),
            .clr_i        (glitch_clr_i[i]),
            .gpio_o       (gpio_o[i]),
            .rise_o       (rise_o[i]),
            .fall_o       (fall_o[i]),
            .glitch_cnt_o (glitch_cnt_o[i*IguanaGpioGlitchW +: IguanaGpioGlitchW])
        );
    end

endmodule
